// File: rtl/bam_pkg.sv
// Shared constants and helpers for the blood abnormality monitor.
// Holds the default pH windows, the default rule mask and the width helper.
package bam_pkg;

    localparam int P_LO_DEF = 7;
    localparam int P_HI_DEF = 8;
    localparam int Q_LO_DEF = 6;
    localparam int Q_HI_DEF = 9;

    localparam logic [7:0] CLASS_MASK_DEF = 8'b1010_1010;

    // Returns clog2(n), but never less than 1, so a single channel still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bam_classifier.sv
// Combinational pH classifier: picks the P or Q window from the blood-type mask
// and flags a sample that lies outside the selected inclusive window.
module bam_classifier
    import bam_pkg::*;
#(
    parameter int                    PH_W       = 4,
    parameter int                    TYPE_W     = 3,
    parameter logic [2**TYPE_W-1:0]  CLASS_MASK = CLASS_MASK_DEF,
    parameter int                    P_LO       = P_LO_DEF,
    parameter int                    P_HI       = P_HI_DEF,
    parameter int                    Q_LO       = Q_LO_DEF,
    parameter int                    Q_HI       = Q_HI_DEF
)(
    input  logic [PH_W-1:0]   i_ph,
    input  logic [TYPE_W-1:0] i_type,
    output logic              o_abnormal
);

    logic w_rule_q;
    logic w_out_p;
    logic w_out_q;

    assign w_rule_q = CLASS_MASK[i_type];
    assign w_out_p  = (i_ph < PH_W'(P_LO)) || (i_ph > PH_W'(P_HI));
    assign w_out_q  = (i_ph < PH_W'(Q_LO)) || (i_ph > PH_W'(Q_HI));

    assign o_abnormal = w_rule_q ? w_out_q : w_out_p;

endmodule

// File: rtl/blood_abnormality_monitor.sv
// Per-channel persistence monitor: counts consecutive abnormal pH samples,
// latches an alarm at PERSIST, and pulses an event on each alarm rise.
module blood_abnormality_monitor
    import bam_pkg::*;
#(
    parameter int                    NUM_CH     = 4,
    parameter int                    PH_W       = 4,
    parameter int                    TYPE_W     = 3,
    parameter int                    PERSIST    = 3,
    parameter logic [2**TYPE_W-1:0]  CLASS_MASK = CLASS_MASK_DEF,
    parameter int                    P_LO       = P_LO_DEF,
    parameter int                    P_HI       = P_HI_DEF,
    parameter int                    Q_LO       = Q_LO_DEF,
    parameter int                    Q_HI       = Q_HI_DEF,
    localparam int                   CH_W       = clog2_min1(NUM_CH)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [PH_W-1:0]   bloodPH,
    input  logic [TYPE_W-1:0] bloodType,
    input  logic              clr_valid,
    input  logic [CH_W-1:0]   clr_ch,
    output logic [NUM_CH-1:0] alarm,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    output logic              bloodAbnormality
);

    localparam int CNT_W = clog2_min1(PERSIST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST);

    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_alarm;
    logic              r_ready;
    logic              r_evt_valid;
    logic [CH_W-1:0]   r_evt_ch;
    logic              r_abn;

    logic              w_abn;
    logic              w_accept;
    logic              w_in_ok;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_smp;
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_alarm_nxt;
    logic [NUM_CH-1:0] w_rise;
    logic [CH_W-1:0]   w_rise_ch;

    bam_classifier #(
        .PH_W       (PH_W),
        .TYPE_W     (TYPE_W),
        .CLASS_MASK (CLASS_MASK),
        .P_LO       (P_LO),
        .P_HI       (P_HI),
        .Q_LO       (Q_LO),
        .Q_HI       (Q_HI)
    ) u_classifier (
        .i_ph       (bloodPH),
        .i_type     (bloodType),
        .o_abnormal (w_abn)
    );

    assign w_accept = in_valid && r_ready;
    assign w_in_ok  = 32'(in_ch) < 32'(NUM_CH);

    // A clear on a channel overrides any sample landing on it in the same cycle.
    always_comb begin
        w_clr       = '0;
        w_smp       = '0;
        w_alarm_nxt = r_alarm;
        w_rise_ch   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_cnt_nxt[ch] = r_cnt[ch];
            w_clr[ch]     = clr_valid && (clr_ch == CH_W'(ch));
            w_smp[ch]     = w_accept && (in_ch == CH_W'(ch));
            if (w_clr[ch]) begin
                w_cnt_nxt[ch]   = '0;
                w_alarm_nxt[ch] = 1'b0;
            end else if (w_smp[ch]) begin
                if (w_abn) begin
                    w_cnt_nxt[ch] = (r_cnt[ch] == CNT_MAX) ? r_cnt[ch] : r_cnt[ch] + CNT_W'(1);
                    if (w_cnt_nxt[ch] == CNT_MAX) begin
                        w_alarm_nxt[ch] = 1'b1;
                    end
                end else begin
                    w_cnt_nxt[ch] = '0;
                end
            end
        end
        w_rise = w_alarm_nxt & ~r_alarm;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (w_rise[ch]) begin
                w_rise_ch = CH_W'(ch);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_cnt[ch] <= '0;
            end
            r_alarm     <= '0;
            r_ready     <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_abn       <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_cnt[ch] <= w_cnt_nxt[ch];
            end
            r_alarm     <= w_alarm_nxt;
            r_ready     <= 1'b1;
            r_evt_valid <= |w_rise;
            if (|w_rise) begin
                r_evt_ch <= w_rise_ch;
            end
            if (w_accept && w_in_ok) begin
                r_abn <= w_abn;
            end
        end
    end

    assign in_ready         = r_ready;
    assign alarm            = r_alarm;
    assign evt_valid        = r_evt_valid;
    assign evt_ch           = r_evt_ch;
    assign bloodAbnormality = r_abn;

endmodule

// File: tb/tb_blood_abnormality_monitor.sv
// Directed bench for blood_abnormality_monitor (default build plus a PERSIST=1 build).
module tb_blood_abnormality_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_ch;
    logic [3:0] bloodPH;
    logic [2:0] bloodType;
    logic       clr_valid;
    logic [1:0] clr_ch;

    logic       in_ready,   p1_in_ready;
    logic [3:0] alarm,      p1_alarm;
    logic       evt_valid,  p1_evt_valid;
    logic [1:0] evt_ch,     p1_evt_ch;
    logic       abn,        p1_abn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    blood_abnormality_monitor dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .bloodPH(bloodPH), .bloodType(bloodType),
        .clr_valid(clr_valid), .clr_ch(clr_ch), .alarm(alarm),
        .evt_valid(evt_valid), .evt_ch(evt_ch), .bloodAbnormality(abn)
    );

    blood_abnormality_monitor #(.PERSIST(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p1_in_ready),
        .in_ch(in_ch), .bloodPH(bloodPH), .bloodType(bloodType),
        .clr_valid(clr_valid), .clr_ch(clr_ch), .alarm(p1_alarm),
        .evt_valid(p1_evt_valid), .evt_ch(p1_evt_ch), .bloodAbnormality(p1_abn)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; outputs are observable on return.
    task automatic drive(input logic v, input logic [1:0] ch, input logic [3:0] ph,
                         input logic [2:0] typ, input logic cv, input logic [1:0] cch);
        @(negedge clk);
        in_valid  = v;
        in_ch     = ch;
        bloodPH   = ph;
        bloodType = typ;
        clr_valid = cv;
        clr_ch    = cch;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clr_valid = 1'b0;
    endtask

    task automatic smp(input logic [1:0] ch, input logic [3:0] ph, input logic [2:0] typ);
        drive(1'b1, ch, ph, typ, 1'b0, 2'd0);
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 4'd0, 3'd0, 1'b0, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; bloodPH = '0; bloodType = '0;
        clr_valid = 1'b0; clr_ch = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alarm", 32'(alarm), 32'h0);
        chk("rst_evt", 32'(evt_valid), 32'h0);
        chk("rst_evt_ch", 32'(evt_ch), 32'h0);
        chk("rst_abn", 32'(abn), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h0);

        // Warm-up: a sample offered on the first clock after release must be refused.
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_ch = 2'd1; bloodPH = 4'd3; bloodType = 3'd0;
        #1;
        chk("warm_ready0", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("warm_ready1", 32'(in_ready), 32'h1);
        chk("warm_abn", 32'(abn), 32'h0);
        chk("warm_p1_alarm", 32'(p1_alarm), 32'h0);

        // ch1, P rule, three abnormal samples
        smp(2'd1, 4'd3, 3'd0);
        chk("s1_abn", 32'(abn), 32'h1);
        chk("s1_alarm", 32'(alarm), 32'h0);
        chk("p1_alarm_first", 32'(p1_alarm), 32'h2);
        chk("p1_evt_first", 32'(p1_evt_valid), 32'h1);
        smp(2'd1, 4'd3, 3'd0);
        chk("s2_alarm", 32'(alarm), 32'h0);
        chk("s2_evt", 32'(evt_valid), 32'h0);
        smp(2'd1, 4'd3, 3'd0);
        chk("s3_alarm", 32'(alarm), 32'h2);
        chk("s3_evt", 32'(evt_valid), 32'h1);
        chk("s3_evt_ch", 32'(evt_ch), 32'h1);
        idle();
        chk("evt_one_cycle", 32'(evt_valid), 32'h0);
        chk("evt_ch_held", 32'(evt_ch), 32'h1);
        smp(2'd1, 4'd3, 3'd0);
        chk("s4_no_evt", 32'(evt_valid), 32'h0);
        chk("s4_alarm", 32'(alarm), 32'h2);
        smp(2'd1, 4'd7, 3'd0);
        chk("normal_abn", 32'(abn), 32'h0);
        chk("normal_keeps_alarm", 32'(alarm), 32'h2);

        // ch2: a normal sample restarts the run
        smp(2'd2, 4'd3, 3'd0);
        smp(2'd2, 4'd3, 3'd0);
        smp(2'd2, 4'd7, 3'd0);
        chk("ch2_norm_abn", 32'(abn), 32'h0);
        smp(2'd2, 4'd3, 3'd0);
        smp(2'd2, 4'd3, 3'd0);
        chk("ch2_no_alarm", 32'(alarm), 32'h2);

        // Window edges on ch2 (count stays below PERSIST throughout)
        smp(2'd2, 4'd8, 3'd0);  chk("p_hi_edge", 32'(abn), 32'h0);
        smp(2'd2, 4'd9, 3'd0);  chk("p_above", 32'(abn), 32'h1);
        smp(2'd2, 4'd6, 3'd1);  chk("q_lo_edge", 32'(abn), 32'h0);
        smp(2'd2, 4'd5, 3'd1);  chk("q_below", 32'(abn), 32'h1);
        smp(2'd2, 4'd6, 3'd2);  chk("p_below_t2", 32'(abn), 32'h1);
        smp(2'd2, 4'd9, 3'd3);  chk("q_hi_edge_t3", 32'(abn), 32'h0);
        chk("ch2_edges_alarm", 32'(alarm), 32'h2);

        // ch0, Q rule: 9 is in-window, 10 is not
        for (int i = 0; i < 3; i++) smp(2'd0, 4'd9, 3'd1);
        chk("q9_no_alarm", 32'(alarm), 32'h2);
        smp(2'd0, 4'd10, 3'd1);
        smp(2'd0, 4'd10, 3'd1);
        chk("q10_two", 32'(alarm), 32'h2);
        smp(2'd0, 4'd10, 3'd1);
        chk("q10_alarm", 32'(alarm), 32'h3);
        chk("q10_evt", 32'(evt_valid), 32'h1);
        chk("q10_evt_ch", 32'(evt_ch), 32'h0);

        // Clear on ch1 colliding with an abnormal ch1 sample: clear wins
        smp(2'd3, 4'd3, 3'd0);
        smp(2'd3, 4'd3, 3'd0);
        drive(1'b1, 2'd1, 4'd3, 3'd0, 1'b1, 2'd1);
        chk("clr_same_alarm", 32'(alarm), 32'h1);
        chk("clr_same_abn", 32'(abn), 32'h1);
        chk("clr_same_evt", 32'(evt_valid), 32'h0);
        smp(2'd1, 4'd3, 3'd0);
        smp(2'd1, 4'd3, 3'd0);
        chk("clr_cnt_zero", 32'(alarm), 32'h1);
        smp(2'd1, 4'd3, 3'd0);
        chk("ch1_rearm", 32'(alarm), 32'h3);
        // Clear on ch1 alongside the third abnormal ch3 sample: both apply
        drive(1'b1, 2'd3, 4'd3, 3'd0, 1'b1, 2'd1);
        chk("clr_diff_alarm", 32'(alarm), 32'h9);
        chk("clr_diff_evt", 32'(evt_valid), 32'h1);
        chk("clr_diff_evt_ch", 32'(evt_ch), 32'h3);

        // Reset in the middle of a run discards history
        smp(2'd1, 4'd3, 3'd0);
        smp(2'd1, 4'd3, 3'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_alarm", 32'(alarm), 32'h0);
        chk("mid_rst_evt", 32'(evt_valid), 32'h0);
        chk("mid_rst_abn", 32'(abn), 32'h0);
        chk("mid_rst_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        smp(2'd1, 4'd3, 3'd0);
        chk("post_rst_one", 32'(alarm), 32'h0);
        chk("post_rst_evt", 32'(evt_valid), 32'h0);
        smp(2'd1, 4'd3, 3'd0);
        chk("post_rst_two", 32'(alarm), 32'h0);
        smp(2'd1, 4'd3, 3'd0);
        chk("post_rst_three", 32'(alarm), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1);
    end

endmodule
